// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and the shared data bus.
// Latches one request, runs the bus access, and reports completion or misalignment.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   req_*                access request from the execute stage
//   req_ready, busy      handshake and pipeline hold
//   resp_*               completion pulse, load result, misalign flag
//   stall_lw             first-cycle strobe of a load (program memory read)
//   data_bus_*           shared tri-state data bus and its controls
module load_store_unit #(
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        stall_lw,
    inout  wire  [31:0] data_bus_data,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    output logic [1:0]  data_bus_reqw,
    output logic        data_bus_reqs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_STROBE,
        S_LD_WAIT,
        S_LD_CAPTURE,
        S_ST_WRITE,
        S_ERR
    } state_e;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam logic [3:0] EW = 4'(EXTRA_WAIT);
    // Last count value of LD_WAIT; unused when EXTRA_WAIT is 0.
    localparam logic [3:0] EW_LAST =
        (EXTRA_WAIT == 0) ? 4'd0 : 4'(EXTRA_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  reqw_q, reqw_d;
    logic        reqs_q, reqs_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        rmis_q, rmis_d;

    logic        idle;
    logic        misalign;

    assign idle = (state_q == S_IDLE);

    // Width code 11 behaves as a word. Half-words only straddle a
    // word boundary at offset 3.
    always_comb begin
        misalign = 1'b0;
        unique case (req_width)
            2'b01:   misalign = (req_addr[1:0] == 2'b11);
            2'b10:   misalign = 1'b0;
            default: misalign = (req_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        reqw_d   = reqw_q;
        reqs_d   = reqs_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rmis_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    reqw_d  = req_width;
                    reqs_d  = req_signed;
                    wait_d  = 4'd0;
                    if (misalign) begin
                        state_d = S_ERR;
                    end else if (req_write) begin
                        state_d = S_ST_WRITE;
                    end else begin
                        state_d = S_LD_STROBE;
                    end
                end
            end
            S_LD_STROBE: begin
                wait_d  = 4'd0;
                state_d = (EXTRA_WAIT == 0) ? S_LD_CAPTURE : S_LD_WAIT;
            end
            S_LD_WAIT: begin
                if (wait_q == EW_LAST) begin
                    state_d = S_LD_CAPTURE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_LD_CAPTURE: begin
                rdata_d  = data_bus_data;
                rvalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            S_ST_WRITE: begin
                // Write phase lasts 1 + EXTRA_WAIT cycles.
                if (wait_q == EW) begin
                    rvalid_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_ERR: begin
                rvalid_d = 1'b1;
                rmis_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wait_q   <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            reqw_q   <= 2'b00;
            reqs_q   <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            rmis_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            reqw_q   <= reqw_d;
            reqs_q   <= reqs_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rmis_q   <= rmis_d;
        end
    end

    always_comb begin
        data_bus_mode = MODE_IDLE;
        unique case (state_q)
            S_LD_STROBE,
            S_LD_WAIT,
            S_LD_CAPTURE: data_bus_mode = MODE_READ;
            S_ST_WRITE:   data_bus_mode = MODE_WRITE;
            default:      data_bus_mode = MODE_IDLE;
        endcase
    end

    // Only the write phase drives the bus; loads leave it to the target.
    assign data_bus_data =
        (state_q == S_ST_WRITE) ? wdata_q : 32'bz;

    assign req_ready     = idle;
    assign busy          = (req_valid && idle) || !idle;
    assign stall_lw      = (state_q == S_LD_STROBE);
    assign resp_valid    = rvalid_q;
    assign resp_misalign = rmis_q;
    assign resp_rdata    = rdata_q;
    assign data_bus_addr = addr_q;
    assign data_bus_reqw = reqw_q;
    assign data_bus_reqs = reqs_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit.
// Two instances: EXTRA_WAIT = 0 (dut0) and EXTRA_WAIT = 3 (dut3).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv0, rv3;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy0, busy0, rval0, mis0, stall0, reqs0;
    logic [31:0] rdata0, addr0;
    logic [1:0]  mode0, reqw0;
    wire  [31:0] bus0;
    logic [31:0] tdata0;
    logic        force0;

    logic        rdy3, busy3, rval3, mis3, stall3, reqs3;
    logic [31:0] rdata3, addr3;
    logic [1:0]  mode3, reqw3;
    wire  [31:0] bus3;
    logic [31:0] tdata3;
    logic        force3;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Bus target: answers whenever a read is in progress, or on demand
    // to prove the unit has released the bus.
    assign bus0 = (mode0 == 2'b01 || force0) ? tdata0 : 32'bz;
    assign bus3 = (mode3 == 2'b01 || force3) ? tdata3 : 32'bz;

    load_store_unit #(.EXTRA_WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv0), .req_write(req_write),
        .req_width(req_width), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy0), .busy(busy0),
        .resp_valid(rval0), .resp_rdata(rdata0),
        .resp_misalign(mis0), .stall_lw(stall0),
        .data_bus_data(bus0), .data_bus_addr(addr0),
        .data_bus_mode(mode0), .data_bus_reqw(reqw0),
        .data_bus_reqs(reqs0)
    );

    load_store_unit #(.EXTRA_WAIT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_write(req_write),
        .req_width(req_width), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy3), .busy(busy3),
        .resp_valid(rval3), .resp_rdata(rdata3),
        .resp_misalign(mis3), .stall_lw(stall3),
        .data_bus_data(bus3), .data_bus_addr(addr3),
        .data_bus_mode(mode3), .data_bus_reqw(reqw3),
        .data_bus_reqs(reqs3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [1:0] wd,
                           input logic s, input logic [31:0] a,
                           input logic [31:0] d);
        req_write  = w;
        req_width  = wd;
        req_signed = s;
        req_addr   = a;
        req_wdata  = d;
    endtask

    // Packs {mode, stall, resp_valid, misalign, busy, ready}.
    function automatic logic [6:0] st0();
        return {mode0, stall0, rval0, mis0, busy0, rdy0};
    endfunction

    function automatic logic [6:0] st3();
        return {mode3, stall3, rval3, mis3, busy3, rdy3};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (st0() !== 7'b00_0_0_0_0_1) begin
            errs++;
            $display("FAIL reset_ctl0: got %b want %b", st0(), 7'b0000001);
        end
        checks++;
        if ({addr0, rdata0, reqw0, reqs0} !== 67'd0) begin
            errs++;
            $display("FAIL reset_regs0: got %h %h %b %b",
                     addr0, rdata0, reqw0, reqs0);
        end
        checks++;
        if (st3() !== 7'b00_0_0_0_0_1) begin
            errs++;
            $display("FAIL reset_ctl3: got %b want %b", st3(), 7'b0000001);
        end
        force0 = 1'b1;
        tdata0 = 32'hA5A5_5A5A;
        #1;
        checks++;
        if (bus0 !== 32'hA5A5_5A5A) begin
            errs++;
            $display("FAIL reset_bus0: got %h want a5a55a5a", bus0);
        end
        force0 = 1'b0;
    endtask

    task automatic test_load_word;
        set_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        tdata0 = 32'hDEAD_BEEF;
        rv0 = 1'b1;
        #1;
        checks++;
        if (busy0 !== 1'b1) begin
            errs++;
            $display("FAIL ld_busy_accept: got %b want 1", busy0);
        end
        tick();
        rv0 = 1'b0;
        set_req(1'b1, 2'b10, 1'b1, 32'hFFFF_FFF0, 32'h0);
        checks++;
        if (st0() !== 7'b01_1_0_0_1_0) begin
            errs++;
            $display("FAIL ld_strobe: got %b want %b", st0(), 7'b0110010);
        end
        checks++;
        if ({addr0, reqw0, reqs0} !== {32'h100, 2'b00, 1'b0}) begin
            errs++;
            $display("FAIL ld_latch: got %h %b %b want 100 00 0",
                     addr0, reqw0, reqs0);
        end
        tick();
        checks++;
        if (st0() !== 7'b01_0_0_0_1_0) begin
            errs++;
            $display("FAIL ld_capture: got %b want %b", st0(), 7'b0100010);
        end
        tick();
        checks++;
        if (st0() !== 7'b00_0_1_0_0_1) begin
            errs++;
            $display("FAIL ld_resp: got %b want %b", st0(), 7'b0001001);
        end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL ld_rdata: got %h want deadbeef", rdata0);
        end
        tick();
        checks++;
        if (rval0 !== 1'b0) begin
            errs++;
            $display("FAIL ld_pulse: got %b want 0", rval0);
        end
    endtask

    task automatic test_store_word;
        set_req(1'b1, 2'b00, 1'b0, 32'h2004, 32'h1234_5678);
        rv0 = 1'b1;
        tick();
        rv0 = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFFF);
        checks++;
        if (st0() !== 7'b10_0_0_0_1_0) begin
            errs++;
            $display("FAIL st_write: got %b want %b", st0(), 7'b1000010);
        end
        checks++;
        if ({bus0, addr0} !== {32'h1234_5678, 32'h2004}) begin
            errs++;
            $display("FAIL st_bus: got %h @%h want 12345678 @2004",
                     bus0, addr0);
        end
        tick();
        checks++;
        if (st0() !== 7'b00_0_1_0_0_1) begin
            errs++;
            $display("FAIL st_resp: got %b want %b", st0(), 7'b0001001);
        end
        checks++;
        if (rdata0 !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL st_rdata_kept: got %h want deadbeef", rdata0);
        end
        force0 = 1'b1;
        tdata0 = 32'h0F0F_0F0F;
        #1;
        checks++;
        if (bus0 !== 32'h0F0F_0F0F) begin
            errs++;
            $display("FAIL st_release: got %h want 0f0f0f0f", bus0);
        end
        force0 = 1'b0;
    endtask

    task automatic test_misalign;
        logic [1:0]  wd [2] = '{2'b01, 2'b00};
        logic [31:0] ad [2] = '{32'h103, 32'h102};
        for (int i = 0; i < 2; i++) begin
            set_req(1'b0, wd[i], 1'b0, ad[i], 32'h0);
            rv0 = 1'b1;
            tick();
            rv0 = 1'b0;
            checks++;
            if (st0() !== 7'b00_0_0_0_1_0) begin
                errs++;
                $display("FAIL mis_err%0d: got %b want %b",
                         i, st0(), 7'b0000010);
            end
            tick();
            checks++;
            if (st0() !== 7'b00_0_1_1_0_1) begin
                errs++;
                $display("FAIL mis_resp%0d: got %b want %b",
                         i, st0(), 7'b0001101);
            end
            checks++;
            if (rdata0 !== 32'hDEAD_BEEF) begin
                errs++;
                $display("FAIL mis_rdata%0d: got %h want deadbeef",
                         i, rdata0);
            end
        end
        tick();
        checks++;
        if (mis0 !== 1'b0) begin
            errs++;
            $display("FAIL mis_pulse: got %b want 0", mis0);
        end
    endtask

    task automatic test_back_to_back;
        set_req(1'b0, 2'b10, 1'b0, 32'h201, 32'h0);
        tdata0 = 32'h0000_00CA;
        rv0 = 1'b1;
        tick();
        rv0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rval0, rdy0, rdata0} !== {2'b11, 32'h0000_00CA}) begin
            errs++;
            $display("FAIL b2b_ld_resp: got %b%b %h want 11 000000ca",
                     rval0, rdy0, rdata0);
        end
        set_req(1'b1, 2'b00, 1'b0, 32'h204, 32'h0BAD_C0DE);
        rv0 = 1'b1;
        #1;
        checks++;
        if (busy0 !== 1'b1) begin
            errs++;
            $display("FAIL b2b_busy: got %b want 1", busy0);
        end
        tick();
        rv0 = 1'b0;
        checks++;
        if (st0() !== 7'b10_0_0_0_1_0) begin
            errs++;
            $display("FAIL b2b_st: got %b want %b", st0(), 7'b1000010);
        end
        checks++;
        if ({bus0, addr0} !== {32'h0BAD_C0DE, 32'h204}) begin
            errs++;
            $display("FAIL b2b_bus: got %h @%h want 0badc0de @204",
                     bus0, addr0);
        end
        tick();
        checks++;
        if (st0() !== 7'b00_0_1_0_0_1) begin
            errs++;
            $display("FAIL b2b_st_resp: got %b want %b",
                     st0(), 7'b0001001);
        end
    endtask

    task automatic test_extra_wait;
        set_req(1'b0, 2'b10, 1'b1, 32'h301, 32'h0);
        tdata3 = 32'hFFFF_FF80;
        rv3 = 1'b1;
        tick();
        rv3 = 1'b0;
        checks++;
        if (st3() !== 7'b01_1_0_0_1_0) begin
            errs++;
            $display("FAIL ew_strobe: got %b want %b", st3(), 7'b0110010);
        end
        checks++;
        if ({addr3, reqw3, reqs3} !== {32'h301, 2'b10, 1'b1}) begin
            errs++;
            $display("FAIL ew_latch: got %h %b %b want 301 10 1",
                     addr3, reqw3, reqs3);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++;
            if (st3() !== 7'b01_0_0_0_1_0) begin
                errs++;
                $display("FAIL ew_rd_cyc%0d: got %b want %b",
                         c, st3(), 7'b0100010);
            end
        end
        tick();
        checks++;
        if ({st3(), rdata3} !== {7'b00_0_1_0_0_1, 32'hFFFF_FF80}) begin
            errs++;
            $display("FAIL ew_resp: got %b %h want 0001001 ffffff80",
                     st3(), rdata3);
        end
        set_req(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_BEEF);
        rv3 = 1'b1;
        tick();
        rv3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({st3(), bus3} !== {7'b10_0_0_0_1_0, 32'h0000_BEEF}) begin
                errs++;
                $display("FAIL ew_st_cyc%0d: got %b %h want 1000010 0000beef",
                         c, st3(), bus3);
            end
            tick();
        end
        checks++;
        if ({st3(), rdata3} !== {7'b00_0_1_0_0_1, 32'hFFFF_FF80}) begin
            errs++;
            $display("FAIL ew_st_resp: got %b %h want 0001001 ffffff80",
                     st3(), rdata3);
        end
    endtask

    task automatic test_reset_mid;
        set_req(1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
        tdata3 = 32'h5555_AAAA;
        rv3 = 1'b1;
        tick();
        rv3 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (st3() !== 7'b00_0_0_0_0_1) begin
            errs++;
            $display("FAIL rst_mid_ctl: got %b want %b", st3(), 7'b0000001);
        end
        checks++;
        if ({addr3, rdata3, reqw3, reqs3} !== 67'd0) begin
            errs++;
            $display("FAIL rst_mid_regs: got %h %h %b %b",
                     addr3, rdata3, reqw3, reqs3);
        end
        force3 = 1'b1;
        tdata3 = 32'h3C3C_3C3C;
        #1;
        checks++;
        if (bus3 !== 32'h3C3C_3C3C) begin
            errs++;
            $display("FAIL rst_mid_bus: got %h want 3c3c3c3c", bus3);
        end
        force3 = 1'b0;
        tick();
        checks++;
        if (rval3 !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_nopulse: got %b want 0", rval3);
        end
        set_req(1'b0, 2'b00, 1'b0, 32'h408, 32'h0);
        tdata3 = 32'h1122_3344;
        rv3 = 1'b1;
        tick();
        rv3 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (rval3 !== 1'b0) begin
                errs++;
                $display("FAIL rst_mid_early%0d: got %b want 0", c, rval3);
            end
            tick();
        end
        checks++;
        if ({rval3, rdata3, addr3} !== {1'b1, 32'h1122_3344, 32'h408}) begin
            errs++;
            $display("FAIL rst_mid_reload: got %b %h @%h want 1 11223344 @408",
                     rval3, rdata3, addr3);
        end
    endtask

    initial begin
        reset  = 1'b1;
        rv0    = 1'b0;
        rv3    = 1'b0;
        force0 = 1'b0;
        force3 = 1'b0;
        tdata0 = 32'h0;
        tdata3 = 32'h0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_load_word();
        test_store_word();
        test_misalign();
        test_back_to_back();
        test_extra_wait();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
